// File: rtl/ad9361_tdd_sequencer_pkg.sv
// ad9361_tdd_sequencer_pkg: shared state encoding, width defaults and per-state ENSM pin values
package ad9361_tdd_sequencer_pkg;
   localparam int CNT_WIDTH_DEF = 24;
   localparam int FRM_WIDTH_DEF = 16;
   localparam int SYNC_STAGES_DEF = 2;
   typedef enum logic [2:0] {IDLE, ARMED, RX_GUARD, RX_ON, TX_GUARD, TX_ON} state_t;
   function automatic logic [1:0] state_out(input state_t s);
      return {s == TX_GUARD || s == TX_ON, s == RX_ON || s == TX_ON};
   endfunction
endpackage

// File: rtl/ad9361_tdd_sequencer_sync_edge.sv
// ad9361_tdd_sequencer_sync_edge: multi-flop synchroniser with a one-cycle rising-edge pulse
module ad9361_tdd_sequencer_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);
   logic [STAGES-1:0] sync_q;
   logic              last_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         last_q <= sync_q[STAGES-1];
      end
   end
   assign pulse = sync_q[STAGES-1] & ~last_q;
endmodule

// File: rtl/ad9361_tdd_sequencer.sv
// ad9361_tdd_sequencer: TDD frame scheduler driving AD9361 ENSM enable/txnrx with GPIO bypass
module ad9361_tdd_sequencer
   import ad9361_tdd_sequencer_pkg::*;
#(
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int FRM_WIDTH   = FRM_WIDTH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                 axi_aclk,
   input  logic                 axi_aresetn,
   input  logic                 tdd_en,
   input  logic                 sync_en,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_WIDTH-1:0] rx_len,
   input  logic [CNT_WIDTH-1:0] tx_len,
   input  logic [CNT_WIDTH-1:0] guard_len,
   input  logic [FRM_WIDTH-1:0] burst_count,
   input  logic                 up_enable,
   input  logic                 up_txnrx,
   input  logic                 tdd_sync_i,
   output logic                 tdd_sync_o,
   output logic                 enable,
   output logic                 txnrx,
   output logic                 busy,
   output logic [FRM_WIDTH-1:0] frame_cnt,
   output logic                 done,
   output logic                 cfg_err
);
   state_t               state, state_nx;
   logic [CNT_WIDTH-1:0] cnt, cnt_nx, rx_q, tx_q, gd_q, g_in, g_ld;
   logic [FRM_WIDTH-1:0] burst_q, frame_inc;
   logic                 slave_q, sync_pulse, halt, last, start_ok, accept, finish;
   logic                 err_nx, done_nx, sync_nx, bypass;
   logic [1:0]           out_nx;

   ad9361_tdd_sequencer_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (axi_aclk),
      .rst_n (axi_aresetn),
      .d     (tdd_sync_i),
      .pulse (sync_pulse)
   );

   always_comb begin
      halt      = state != IDLE && (abort || !tdd_en);
      last      = cnt == '0;
      frame_inc = frame_cnt + 1'b1;
      finish    = state == TX_ON && last && burst_q != '0 && frame_inc == burst_q;
      start_ok  = state == IDLE && start && tdd_en && !abort;
      err_nx    = start_ok && (rx_len == '0 || tx_len == '0);
      accept    = start_ok && !err_nx;
      g_in      = guard_len == '0 ? '0 : guard_len - 1'b1;
      g_ld      = state == IDLE ? g_in : gd_q;
      state_nx  = state;
      case (state)
         IDLE:     if (accept) state_nx = sync_en ? ARMED : RX_GUARD;
         ARMED:    if (sync_pulse) state_nx = RX_GUARD;
         RX_GUARD: if (last) state_nx = RX_ON;
         RX_ON:    if (last) state_nx = TX_GUARD;
         TX_GUARD: if (last) state_nx = TX_ON;
         TX_ON:    if (last) state_nx = finish ? IDLE : RX_GUARD;
         default:  state_nx = IDLE;
      endcase
      if (halt) state_nx = IDLE;
      cnt_nx  = state_nx == state ? cnt - 1'b1 :
                state_nx == RX_ON ? rx_q - 1'b1 :
                state_nx == TX_ON ? tx_q - 1'b1 : g_ld;
      bypass  = state == IDLE && state_nx == IDLE && !tdd_en;
      out_nx  = bypass ? {up_txnrx, up_enable} : state_out(state_nx);
      sync_nx = state_nx == RX_GUARD && state != RX_GUARD && (state == IDLE || !slave_q);
      done_nx = finish && !halt;
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state      <= IDLE;
         cnt        <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         gd_q       <= '0;
         burst_q    <= '0;
         slave_q    <= 1'b0;
         frame_cnt  <= '0;
         enable     <= 1'b0;
         txnrx      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         tdd_sync_o <= 1'b0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         {txnrx, enable} <= out_nx;
         busy            <= state_nx != IDLE;
         done            <= done_nx;
         cfg_err         <= err_nx;
         tdd_sync_o      <= sync_nx;
         if (accept) begin
            rx_q      <= rx_len;
            tx_q      <= tx_len;
            gd_q      <= g_in;
            burst_q   <= burst_count;
            slave_q   <= sync_en;
            frame_cnt <= '0;
         end else if (state == TX_ON && last && !halt) begin
            frame_cnt <= frame_inc;
         end
      end
   end
endmodule
